hs_fifo_buf: RTL and testbench
==============================

// Module: hs_fifo_buf
// PURPOSE
//  Parametrised multi-entry successor of the single-slot Sender/Receiver buffer. Sits between a
//  four-phase REQ/ACK producer (Sender) and a four-phase REQ/ACK consumer (Receiver). Holds up to
//  DEPTH words, so the producer is never blocked by a slow consumer until the buffer is full.
//  Every control output is registered, and the block raises a sticky consumer-protocol error flag.
// PARAMETERS
//  WIDTH        32  data word width (DI, DO)
//  DEPTH        4   storage entries, >=2; need not be a power of 2
//  SYNC_STAGES  2   flops on each incoming REQ/ACK (0 = already synchronous, 1..3 allowed)
// PORTS
//  clk       in   1                   single clock, rising edge
//  rst_n     in   1                   reset: asynchronous, active-low
//  StoB_REQ  in   1                   producer request; DI stable while high
//  DI        in   WIDTH               producer data
//  BtoS_ACK  out  1                   ack to producer: word captured
//  BtoR_REQ  out  1                   request to consumer: DO valid
//  DO        out  WIDTH               head-of-buffer data, registered
//  RtoB_ACK  in   1                   consumer ack
//  count     out  $clog2(DEPTH+1)     occupied entries
//  full      out  1                   count==DEPTH
//  empty     out  1                   count==0
//  proto_err out  1                   sticky consumer-protocol violation
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - BtoS_ACK=0, BtoR_REQ=0, DO=0, count=0, empty=1, full=0, proto_err=0.
//   - Both FSMs go idle, pointers=0, synchronisers cleared.
//   - Storage array is not reset.
//  Signal naming: req_s/ack_s are StoB_REQ/RtoB_ACK after SYNC_STAGES flops.
//   - Latencies below are in edges after the synchronised value is seen.
//  Write FSM (W_IDLE, W_ACK):
//   - W_IDLE & req_s & !full: mem[wr]<=DI; wr<=wr+1 (wraps DEPTH-1 -> 0); BtoS_ACK<=1; go W_ACK.
//   - W_IDLE & req_s & full: stall; ACK stays 0 until a pop frees an entry.
//   - W_ACK & !req_s: BtoS_ACK<=0; go W_IDLE. One word per REQ pulse, never two.
//   - DI is sampled directly, unsynchronised; the producer holds it stable from REQ rise to ACK rise.
//  Read FSM (R_IDLE, R_SETUP, R_REQ, R_DROP):
//   - R_IDLE & !empty: DO<=mem[rd]; go R_SETUP.
//   - R_SETUP: BtoR_REQ<=1; go R_REQ. DO is stable one edge before REQ rises.
//   - R_REQ & ack_s: BtoR_REQ<=0; pop (rd<=rd+1 with wrap, count-1); go R_DROP.
//   - R_DROP & !ack_s: go R_IDLE.
//   - DO holds its value until the next load.
//   - Empty -> first push: BtoR_REQ rises 2 edges after the push edge.
//  Count: push-only +1; pop-only -1; push and pop on the same edge leaves count unchanged.
//   - full/empty are decoded from the registered count; never overflow or underflow.
//  proto_err: set when ack_s=1 while the read FSM is in R_IDLE or R_SETUP
//   (ACK without REQ, or ACK held over into the next transfer). Cleared only by rst_n.
//   - The FSM keeps working: a stale ACK is ignored until REQ is high.
//  Reset mid-handshake: outputs drop immediately. In-flight and stored words are discarded;
//   no word is duplicated after release.
// TESTING (WIDTH=32, DEPTH=4, SYNC_STAGES=2 unless stated)
//  1. Single word:
//     - DI=7, REQ high -> ACK high 3 edges later, then REQ low -> ACK low.
//     - DO=7, then BtoR_REQ; consumer ACK -> REQ low; count returns 0.
//  2. Fill and stall, consumer idle:
//     - Push 0..4 -> words 0..3 acked; count=4, full=1; 5th REQ gets no ACK.
//     - One pop -> 5th word acked. Drain order is 0,1,2,3,4.
//  3. Wrap-around:
//     - Stream 0..99 with a random-delay consumer -> received exactly 0..99 in order.
//     - No drops; count never exceeds 4. Repeat with DEPTH=3 and SYNC_STAGES=0.
//  4. Simultaneous push and pop:
//     - Align producer capture edge with consumer pop edge at count=2 -> count stays 2; data order kept.
//  5. Protocol error:
//     - Raise RtoB_ACK while BtoR_REQ=0 -> proto_err=1 and remains 1; later transfers still correct.
//  6. Async reset:
//     - Assert rst_n=0 with count=3 and both ACKs high -> all outputs reset with no clock edge.
//     - After release, empty=1 and no spurious BtoR_REQ.

Source files
------------

// File: rtl/hs_fifo_buf.sv
// Multi-entry buffer between a four-phase REQ/ACK producer and a four-phase REQ/ACK consumer.
// All handshake outputs are registered; a sticky flag records consumer ACKs seen without a REQ.
module hs_fifo_buf #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       StoB_REQ,
   input  logic [WIDTH-1:0]           DI,
   output logic                       BtoS_ACK,
   output logic                       BtoR_REQ,
   output logic [WIDTH-1:0]           DO,
   input  logic                       RtoB_ACK,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       proto_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      W_IDLE,
      W_ACK
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_SETUP,
      R_REQ,
      R_DROP
   } rstate_t;

   wstate_t wState, wStateNxt;
   rstate_t rState, rStateNxt;

   logic             req_s;
   logic             ack_s;
   logic             push;
   logic             pop;
   logic             loadDo;
   logic             errSet;
   logic             sAckNxt;
   logic             rReqNxt;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign req_s = StoB_REQ;
         assign ack_s = RtoB_ACK;
      end else if (SYNC_STAGES == 1) begin : g_sync1
         logic reqSync;
         logic ackSync;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reqSync <= 1'b0;
               ackSync <= 1'b0;
            end else begin
               reqSync <= StoB_REQ;
               ackSync <= RtoB_ACK;
            end
         end
         assign req_s = reqSync;
         assign ack_s = ackSync;
      end else begin : g_syncn
         logic [SYNC_STAGES-1:0] reqSync;
         logic [SYNC_STAGES-1:0] ackSync;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               reqSync <= '0;
               ackSync <= '0;
            end else begin
               reqSync <= {reqSync[SYNC_STAGES-2:0], StoB_REQ};
               ackSync <= {ackSync[SYNC_STAGES-2:0], RtoB_ACK};
            end
         end
         assign req_s = reqSync[SYNC_STAGES-1];
         assign ack_s = ackSync[SYNC_STAGES-1];
      end
   endgenerate

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   always_comb begin
      wStateNxt = wState;
      sAckNxt   = BtoS_ACK;
      push      = 1'b0;
      case (wState)
         W_IDLE: begin
            if (req_s && !full) begin
               push      = 1'b1;
               sAckNxt   = 1'b1;
               wStateNxt = W_ACK;
            end
         end
         W_ACK: begin
            if (!req_s) begin
               sAckNxt   = 1'b0;
               wStateNxt = W_IDLE;
            end
         end
         default: begin
            sAckNxt   = 1'b0;
            wStateNxt = W_IDLE;
         end
      endcase
   end

   // A stale ACK in R_IDLE/R_SETUP only raises the flag; it is honoured once REQ is high.
   always_comb begin
      rStateNxt = rState;
      rReqNxt   = BtoR_REQ;
      loadDo    = 1'b0;
      pop       = 1'b0;
      errSet    = ack_s && ((rState == R_IDLE) || (rState == R_SETUP));
      case (rState)
         R_IDLE: begin
            if (!empty) begin
               loadDo    = 1'b1;
               rStateNxt = R_SETUP;
            end
         end
         R_SETUP: begin
            rReqNxt   = 1'b1;
            rStateNxt = R_REQ;
         end
         R_REQ: begin
            if (ack_s) begin
               rReqNxt   = 1'b0;
               pop       = 1'b1;
               rStateNxt = R_DROP;
            end
         end
         R_DROP: begin
            if (!ack_s) begin
               rStateNxt = R_IDLE;
            end
         end
         default: begin
            rReqNxt   = 1'b0;
            rStateNxt = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= DI;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wState    <= W_IDLE;
         rState    <= R_IDLE;
         BtoS_ACK  <= 1'b0;
         BtoR_REQ  <= 1'b0;
         DO        <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         proto_err <= 1'b0;
      end else begin
         wState   <= wStateNxt;
         rState   <= rStateNxt;
         BtoS_ACK <= sAckNxt;
         BtoR_REQ <= rReqNxt;
         if (loadDo) begin
            DO <= mem[rdPtr];
         end
         if (push) begin
            wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (errSet) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hs_fifo_buf.sv
// Bench for hs_fifo_buf: cycle table for a single word, directed corner sequences, and a
// randomized stream on two configurations checked against a queue/occupancy reference model.
module tb_hs_fifo_buf;

   localparam int WIDTH = 32;

   typedef struct {
      logic        req;
      logic [31:0] di;
      logic        ack;
      logic        eSAck;
      logic        eRReq;
      logic [31:0] eDo;
      logic [2:0]  eCnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sReq  [2];
   logic [WIDTH-1:0] sDi   [2];
   logic             rAck  [2];
   logic             bAck  [2];
   logic             bReq  [2];
   logic [WIDTH-1:0] dOut  [2];
   logic             fullS [2];
   logic             emptyS[2];
   logic             perr  [2];
   logic [2:0]       cnt0;
   logic [1:0]       cnt1;
   logic             done  [2];
   logic [31:0]      expQ0[$];
   logic [31:0]      expQ1[$];
   int               depthOf [2] = '{4, 3};
   int               vectors = 0;
   int               miscompares = 0;

   always #5 clk = ~clk;

   hs_fifo_buf #(.WIDTH(WIDTH), .DEPTH(4), .SYNC_STAGES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .StoB_REQ(sReq[0]), .DI(sDi[0]), .BtoS_ACK(bAck[0]),
      .BtoR_REQ(bReq[0]), .DO(dOut[0]), .RtoB_ACK(rAck[0]), .count(cnt0),
      .full(fullS[0]), .empty(emptyS[0]), .proto_err(perr[0]));

   hs_fifo_buf #(.WIDTH(WIDTH), .DEPTH(3), .SYNC_STAGES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .StoB_REQ(sReq[1]), .DI(sDi[1]), .BtoS_ACK(bAck[1]),
      .BtoR_REQ(bReq[1]), .DO(dOut[1]), .RtoB_ACK(rAck[1]), .count(cnt1),
      .full(fullS[1]), .empty(emptyS[1]), .proto_err(perr[1]));

   function automatic logic [2:0] getCnt(input int i);
      return (i == 0) ? cnt0 : {1'b0, cnt1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pushWord(input int i, input logic [31:0] d);
      int n;
      sDi[i]  = d;
      sReq[i] = 1'b1;
      n = 0;
      while (bAck[i] !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check($sformatf("push%0d_ack(%0h)", i, d), 64'(bAck[i]), 64'(1));
      if (bAck[i] === 1'b1) begin
         if (i == 0) expQ0.push_back(d);
         else        expQ1.push_back(d);
      end
      sReq[i] = 1'b0;
      n = 0;
      while (bAck[i] !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check($sformatf("push%0d_ack_drop", i), 64'(bAck[i]), 64'(0));
   endtask

   task automatic popWord(input int i, input int delay, output logic [31:0] d);
      int n;
      n = 0;
      while (bReq[i] !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check($sformatf("pop%0d_req", i), 64'(bReq[i]), 64'(1));
      repeat (delay) tick();
      d       = dOut[i];
      rAck[i] = 1'b1;
      n = 0;
      while (bReq[i] !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      check($sformatf("pop%0d_req_drop", i), 64'(bReq[i]), 64'(0));
      rAck[i] = 1'b0;
   endtask

   task automatic producer(input int i);
      for (int k = 0; k < 100; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         pushWord(i, 32'(k));
      end
   endtask

   task automatic consumer(input int i);
      logic [31:0] d;
      logic [31:0] expv;
      for (int k = 0; k < 100; k++) begin
         popWord(i, int'($urandom_range(0, 5)), d);
         if (i == 0) expv = (expQ0.size() > 0) ? expQ0.pop_front() : 'x;
         else        expv = (expQ1.size() > 0) ? expQ1.pop_front() : 'x;
         check($sformatf("stream%0d_word%0d", i, k), 64'(d), 64'(expv));
      end
      done[i] = 1'b1;
   endtask

   // Occupancy = captures (ACK rises) minus pops (REQ falls), both visible on the same edge as count.
   task automatic monitor();
      int   occ [2];
      logic pA  [2];
      logic pR  [2];
      for (int i = 0; i < 2; i++) begin
         occ[i] = 0;
         pA[i]  = bAck[i];
         pR[i]  = bReq[i];
      end
      for (int c = 0; c < 40000 && !(done[0] && done[1]); c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (bAck[i] && !pA[i]) occ[i]++;
            if (!bReq[i] && pR[i]) occ[i]--;
            pA[i] = bAck[i];
            pR[i] = bReq[i];
            check($sformatf("stream%0d_count", i), 64'(getCnt(i)), 64'(occ[i]));
            check($sformatf("stream%0d_full", i), 64'(fullS[i]), 64'(occ[i] == depthOf[i]));
            check($sformatf("stream%0d_empty", i), 64'(emptyS[i]), 64'(occ[i] == 0));
            check($sformatf("stream%0d_bound", i), 64'(int'(getCnt(i)) <= depthOf[i]), 64'(1));
         end
      end
   endtask

   initial begin
      vec_t        tbl [11];
      logic [31:0] d;
      logic        sawAck;
      logic        sawReq;
      logic        sawCnt;
      int          n;

      tbl = '{
         '{1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0},
         '{1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0},
         '{1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 32'd0, 3'd1},
         '{1'b0, 32'd7, 1'b0, 1'b1, 1'b0, 32'd7, 3'd1},
         '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd7, 3'd1},
         '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd7, 3'd1},
         '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd7, 3'd1},
         '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd7, 3'd0},
         '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd7, 3'd0},
         '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd7, 3'd0},
         '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd7, 3'd0}
      };

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sReq[i] = 1'b0;
         sDi[i]  = '0;
         rAck[i] = 1'b0;
         done[i] = 1'b0;
      end

      // Reset values
      #2;
      check("rst_sack",  64'(bAck[0]),   64'(0));
      check("rst_rreq",  64'(bReq[0]),   64'(0));
      check("rst_do",    64'(dOut[0]),   64'(0));
      check("rst_count", 64'(cnt0),      64'(0));
      check("rst_empty", 64'(emptyS[0]), 64'(1));
      check("rst_full",  64'(fullS[0]),  64'(0));
      check("rst_perr",  64'(perr[0]),   64'(0));
      tick();
      tick();
      rst_n = 1'b1;

      // Single word, cycle by cycle
      for (int k = 0; k < 11; k++) begin
         sReq[0] = tbl[k].req;
         sDi[0]  = tbl[k].di;
         rAck[0] = tbl[k].ack;
         tick();
         check($sformatf("tbl%0d_sack", k),  64'(bAck[0]),   64'(tbl[k].eSAck));
         check($sformatf("tbl%0d_rreq", k),  64'(bReq[0]),   64'(tbl[k].eRReq));
         check($sformatf("tbl%0d_do", k),    64'(dOut[0]),   64'(tbl[k].eDo));
         check($sformatf("tbl%0d_count", k), 64'(cnt0),      64'(tbl[k].eCnt));
         check($sformatf("tbl%0d_empty", k), 64'(emptyS[0]), 64'(tbl[k].eCnt == 3'd0));
         check($sformatf("tbl%0d_perr", k),  64'(perr[0]),   64'(0));
      end

      // Fill and stall with the consumer idle
      for (int k = 0; k < 4; k++) pushWord(0, 32'(k));
      check("fill_count", 64'(cnt0),      64'(4));
      check("fill_full",  64'(fullS[0]), 64'(1));
      check("fill_empty", 64'(emptyS[0]), 64'(0));
      sDi[0]  = 32'd4;
      sReq[0] = 1'b1;
      sawAck  = 1'b0;
      repeat (12) begin
         tick();
         if (bAck[0]) sawAck = 1'b1;
      end
      check("stall_no_ack", 64'(sawAck), 64'(0));
      popWord(0, 0, d);
      check("drain0", 64'(d), 64'(0));
      n = 0;
      while (bAck[0] !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("stall_release_ack", 64'(bAck[0]), 64'(1));
      sReq[0] = 1'b0;
      n = 0;
      while (bAck[0] !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      check("stall_ack_drop", 64'(bAck[0]), 64'(0));
      check("refill_count", 64'(cnt0), 64'(4));
      for (int k = 1; k < 5; k++) begin
         popWord(0, 1, d);
         check($sformatf("drain%0d", k), 64'(d), 64'(k));
      end
      repeat (4) tick();
      check("drained_count", 64'(cnt0),      64'(0));
      check("drained_empty", 64'(emptyS[0]), 64'(1));

      // Push and pop on the same edge at count=2
      pushWord(0, 32'd10);
      pushWord(0, 32'd11);
      n = 0;
      while (bReq[0] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("simul_pre_req",   64'(bReq[0]), 64'(1));
      check("simul_pre_count", 64'(cnt0),    64'(2));
      check("simul_pre_do",    64'(dOut[0]), 64'(10));
      sDi[0]  = 32'd12;
      sReq[0] = 1'b1;
      rAck[0] = 1'b1;
      tick();
      check("simul_e1_count", 64'(cnt0),    64'(2));
      tick();
      check("simul_e2_count", 64'(cnt0),    64'(2));
      check("simul_e2_sack",  64'(bAck[0]), 64'(0));
      tick();
      check("simul_e3_sack",  64'(bAck[0]), 64'(1));
      check("simul_e3_rreq",  64'(bReq[0]), 64'(0));
      check("simul_e3_count", 64'(cnt0),    64'(2));
      sReq[0] = 1'b0;
      rAck[0] = 1'b0;
      n = 0;
      while (bAck[0] !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      popWord(0, 0, d);
      check("simul_next11", 64'(d), 64'(11));
      popWord(0, 2, d);
      check("simul_next12", 64'(d), 64'(12));
      check("simul_count0", 64'(cnt0), 64'(0));

      // ACK with no REQ
      repeat (3) tick();
      check("perr_before", 64'(perr[0]), 64'(0));
      rAck[0] = 1'b1;
      repeat (4) tick();
      check("perr_set", 64'(perr[0]), 64'(1));
      check("perr_noreq", 64'(bReq[0]), 64'(0));
      rAck[0] = 1'b0;
      repeat (5) tick();
      check("perr_sticky", 64'(perr[0]), 64'(1));
      pushWord(0, 32'h33);
      popWord(0, 0, d);
      check("perr_xfer", 64'(d), 64'(32'h33));
      check("perr_still", 64'(perr[0]), 64'(1));
      check("perr_count", 64'(cnt0), 64'(0));

      // Randomized streams on both configurations
      expQ0.delete();
      expQ1.delete();
      fork
         producer(0);
         producer(1);
         consumer(0);
         consumer(1);
         monitor();
      join
      check("stream0_done", 64'(done[0]), 64'(1));
      check("stream1_done", 64'(done[1]), 64'(1));
      check("stream0_left", 64'(expQ0.size()), 64'(0));
      check("stream1_left", 64'(expQ1.size()), 64'(0));
      check("stream1_perr", 64'(perr[1]), 64'(0));

      // Async reset mid-handshake
      repeat (4) tick();
      pushWord(0, 32'h61);
      pushWord(0, 32'h62);
      sDi[0]  = 32'h63;
      sReq[0] = 1'b1;
      n = 0;
      while (bAck[0] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      n = 0;
      while (bReq[0] !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      rAck[0] = 1'b1;
      check("arst_pre_count", 64'(cnt0),    64'(3));
      check("arst_pre_sack",  64'(bAck[0]), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_sack",  64'(bAck[0]),   64'(0));
      check("arst_rreq",  64'(bReq[0]),   64'(0));
      check("arst_do",    64'(dOut[0]),   64'(0));
      check("arst_count", 64'(cnt0),      64'(0));
      check("arst_empty", 64'(emptyS[0]), 64'(1));
      check("arst_full",  64'(fullS[0]),  64'(0));
      check("arst_perr",  64'(perr[0]),   64'(0));
      sReq[0] = 1'b0;
      rAck[0] = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
      sawReq = 1'b0;
      sawCnt = 1'b0;
      repeat (10) begin
         tick();
         if (bReq[0]) sawReq = 1'b1;
         if (cnt0 != 3'd0) sawCnt = 1'b1;
      end
      check("arst_no_req",   64'(sawReq),    64'(0));
      check("arst_no_count", 64'(sawCnt),    64'(0));
      check("arst_empty2",   64'(emptyS[0]), 64'(1));
      pushWord(0, 32'h70);
      popWord(0, 0, d);
      check("arst_xfer", 64'(d), 64'(32'h70));
      sawReq = 1'b0;
      repeat (10) begin
         tick();
         if (bReq[0]) sawReq = 1'b1;
      end
      check("arst_no_dup",  64'(sawReq), 64'(0));
      check("arst_final_count", 64'(cnt0), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
